// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The optional zero-divisor fast path is selected by DIV_ZERO_FASTPATH_EN in the top.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Bits needed to count 0 .. value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;

    // One extra bit keeps the trial comparison exact for divisors above 2^(WIDTH-1).
    always_comb begin
        shifted     = {r_in[WIDTH-1:0], bit_in};
        divisor_ext = {1'b0, divisor};
        if (shifted >= divisor_ext) begin
            r_out = shifted - divisor_ext;
            q_bit = 1'b1;
        end else begin
            r_out = shifted;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_ZERO_FASTPATH_EN to finish a zero-divisor request in a single cycle.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (r_q),
        .bit_in  (qreg_q[WIDTH-1]),
        .divisor (dvsr_q),
        .r_out   (r_next),
        .q_bit   (q_bit)
    );

    // start is honoured in IDLE and in DONE, so back-to-back requests lose no cycle.
    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        qreg_d  = qreg_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            r_d     = '0;
            qreg_d  = dividend;
            dvsr_d  = divisor;
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = (divisor == '0);
`ifdef DIV_ZERO_FASTPATH_EN
            if (divisor == '0) begin
                state_d = DONE;
                quot_d  = '1;
                rem_d   = dividend;
            end
`endif
        end else begin
            case (state_q)
                RUN: begin
                    r_d    = r_next;
                    qreg_d = {qreg_q[WIDTH-2:0], q_bit};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        quot_d  = {qreg_q[WIDTH-2:0], q_bit};
                        rem_d   = r_next[WIDTH-1:0];
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            qreg_q  <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            qreg_q  <= qreg_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and small randomised checks of seq_restoring_divider (WIDTH = 8).
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int errors;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 1 is the one right after the accept edge; done is expected in cycle WIDTH+1.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int exp_lat, input int exp_busy,
                           input string name);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (quotient !== eq) begin
            errors++;
            $display("FAIL %s quotient: got %0d expected %0d", name, quotient, eq);
        end
        checks++;
        if (remainder !== er) begin
            errors++;
            $display("FAIL %s remainder: got %0d expected %0d", name, remainder, er);
        end
        checks++;
        if (div_by_zero !== ez) begin
            errors++;
            $display("FAIL %s div_by_zero: got %0b expected %0b", name, div_by_zero, ez);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
            errors++;
            $display("FAIL %s after_done: done=%0b busy=%0b q=%0d r=%0d expected done=0 busy=0 q=%0d r=%0d",
                     name, done, busy, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d dbz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_directed();
        run_div(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, W + 1, W, "div_200_7");
        run_div(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, W + 1, W, "div_255_1");
        run_div(8'd13,  8'd200, 8'd0,   8'd13, 1'b0, W + 1, W, "div_13_200");
        run_div(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, W + 1, W, "div_255_255");
        run_div(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, W + 1, W, "div_0_5");
        run_div(8'd250, 8'd129, 8'd1,   8'd121, 1'b0, W + 1, W, "div_250_129");
    endtask

    task automatic test_div_zero();
`ifdef DIV_ZERO_FASTPATH_EN
        run_div(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 1, 0, "div_5_0");
`else
        run_div(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, W + 1, W, "div_5_0");
`endif
        run_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, W + 1, W, "div_after_zero");
    endtask

    // start held through two results; operands change mid-run and again feed the DONE-cycle accept.
    task automatic test_back_to_back();
        int t;
        int n_done;
        int t_first;
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        n_done  = 0;
        t_first = 0;
        for (t = 1; t <= 30; t++) begin
            if (t == 3) begin
                dividend = 8'd100;
                divisor  = 8'd9;
            end
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    t_first = t;
                    checks++;
                    if (quotient !== 8'd28 || remainder !== 8'd4) begin
                        errors++;
                        $display("FAIL b2b_first_result: got q=%0d r=%0d expected q=28 r=4",
                                 quotient, remainder);
                    end
                end else if (n_done == 2) begin
                    start = 1'b0;
                    checks++;
                    if (quotient !== 8'd11 || remainder !== 8'd1) begin
                        errors++;
                        $display("FAIL b2b_second_result: got q=%0d r=%0d expected q=11 r=1",
                                 quotient, remainder);
                    end
                    checks++;
                    if (t - t_first !== W + 1) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d expected %0d", t - t_first, W + 1);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (n_done !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 2", n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%0b done=%0b q=%0d r=%0d dbz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %0d active cycles expected 0", n_done);
        end
        run_div(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, W + 1, W, "div_100_9_after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 150; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            run_div(a, b, a / b, a % b, 1'b0, W + 1, W, "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
